// File: rtl/ps2_mouse_device.sv
// PS/2 mouse device side: host command reception, response queue
// and 3-byte stream packets over an open-collector clock/data pair.
module ps2_mouse_device #(
    parameter int HALF_BIT = 2500,
    parameter int RTS_MIN  = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic       mv_valid,
    output logic       mv_ready,
    input  logic [2:0] mv_btn,
    input  logic [8:0] mv_dx,
    input  logic [8:0] mv_dy,
    output logic [7:0] cmd_byte,
    output logic       cmd_tick,
    output logic       reporting_en,
    output logic       busy
);

    localparam int CW = $clog2(RTS_MIN + 2 * HALF_BIT + 2);
    localparam logic [CW-1:0] HB_END   = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] HOLD_END = CW'(2 * HALF_BIT - 1);
    localparam logic [CW-1:0] RTS_END  = CW'(RTS_MIN - 1);
    // synchronizer latency guard before trusting a released clock line
    localparam logic [CW-1:0] SYNC_LAT = CW'(3);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TX_BIT   = 3'd1;
    localparam logic [2:0] S_TX_HOLD  = 3'd2;
    localparam logic [2:0] S_RTS_WAIT = 3'd3;
    localparam logic [2:0] S_RX_BIT   = 3'd4;
    localparam logic [2:0] S_RX_ACK   = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    logic [2:0]    state;
    logic          c_s1, c_s2, d_s1, d_s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] low_cnt;
    logic          clk_lo;
    logic [3:0]    bit_idx;
    logic [10:0]   frame;
    logic          tx_resp;
    logic [9:0]    rx_sr;
    logic [7:0]    q [3];
    logic [1:0]    q_rd;
    logic [1:0]    q_cnt;
    logic [7:0]    pkt [2];
    logic          pkt_rd;
    logic [1:0]    pkt_left;
    logic          por;
    logic [7:0]    byte1;
    logic          rx_ok;

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    assign byte1 = {2'b00, mv_dy[8], mv_dx[8], 1'b1, mv_btn};
    assign rx_ok = rx_sr[9] & (^rx_sr[8:0]);

    assign busy     = (state != S_IDLE);
    assign ps2c_oe  = clk_lo && (state == S_TX_BIT || state == S_RX_BIT
                                 || state == S_RX_ACK);
    assign ps2d_oe  = (state == S_TX_BIT && !frame[bit_idx])
                      || state == S_RX_ACK;
    assign mv_ready = (state == S_IDLE) && reporting_en && (q_cnt == 2'd0)
                      && (pkt_left == 2'd0) && !por && c_s2
                      && (low_cnt == '0);

    // two-flop synchronizers for the sensed bus lines (idle high)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
        end else begin
            c_s1 <= ps2c_in;
            c_s2 <= c_s1;
            d_s1 <= ps2d_in;
            d_s2 <= d_s1;
        end
    end

    // protocol FSM, response queue and packet buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            low_cnt      <= '0;
            clk_lo       <= 1'b0;
            bit_idx      <= 4'd0;
            frame        <= 11'h7ff;
            tx_resp      <= 1'b0;
            rx_sr        <= 10'd0;
            q[0]         <= 8'h00;
            q[1]         <= 8'h00;
            q[2]         <= 8'h00;
            q_rd         <= 2'd0;
            q_cnt        <= 2'd0;
            pkt[0]       <= 8'h00;
            pkt[1]       <= 8'h00;
            pkt_rd       <= 1'b0;
            pkt_left     <= 2'd0;
            por          <= 1'b1;
            cmd_byte     <= 8'h00;
            cmd_tick     <= 1'b0;
            reporting_en <= 1'b0;
        end else begin
            cmd_tick <= 1'b0;
            if (por) begin
                q[0]  <= 8'hAA;
                q[1]  <= 8'h00;
                q_rd  <= 2'd0;
                q_cnt <= 2'd2;
                por   <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    cnt     <= '0;
                    clk_lo  <= 1'b0;
                    bit_idx <= 4'd0;
                    if (!c_s2) begin
                        low_cnt <= low_cnt + CW'(1);
                        if (low_cnt == RTS_END) begin
                            state    <= S_RTS_WAIT;
                            pkt_left <= 2'd0;
                            low_cnt  <= '0;
                        end
                    end else begin
                        low_cnt <= '0;
                        if (q_cnt != 2'd0 && !por) begin
                            state <= S_RESP;
                        end else if (pkt_left != 2'd0) begin
                            frame    <= mk_frame(pkt[pkt_rd]);
                            pkt_rd   <= ~pkt_rd;
                            pkt_left <= pkt_left - 2'd1;
                            tx_resp  <= 1'b0;
                            state    <= S_TX_BIT;
                        end else if (mv_valid && mv_ready) begin
                            pkt[0]   <= mv_dx[7:0];
                            pkt[1]   <= mv_dy[7:0];
                            pkt_rd   <= 1'b0;
                            pkt_left <= 2'd2;
                            frame    <= mk_frame(byte1);
                            tx_resp  <= 1'b0;
                            state    <= S_TX_BIT;
                        end
                    end
                end
                S_RESP: begin
                    frame   <= mk_frame(q[q_rd]);
                    tx_resp <= 1'b1;
                    cnt     <= '0;
                    clk_lo  <= 1'b0;
                    bit_idx <= 4'd0;
                    state   <= S_TX_BIT;
                end
                S_TX_BIT: begin
                    if (!clk_lo) begin
                        if (bit_idx < 4'd9 && cnt >= SYNC_LAT && !c_s2) begin
                            state   <= S_TX_HOLD;
                            cnt     <= '0;
                            low_cnt <= '0;
                        end else if (cnt == HB_END) begin
                            cnt    <= '0;
                            clk_lo <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (cnt == HB_END) begin
                        cnt    <= '0;
                        clk_lo <= 1'b0;
                        if (bit_idx == 4'd10) begin
                            state   <= S_IDLE;
                            bit_idx <= 4'd0;
                            if (tx_resp) begin
                                q_rd  <= q_rd + 2'd1;
                                q_cnt <= q_cnt - 2'd1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_TX_HOLD: begin
                    clk_lo <= 1'b0;
                    if (c_s2) begin
                        low_cnt <= '0;
                        if (cnt == HOLD_END) begin
                            cnt     <= '0;
                            bit_idx <= 4'd0;
                            state   <= S_TX_BIT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        cnt     <= '0;
                        low_cnt <= low_cnt + CW'(1);
                        if (low_cnt == RTS_END) begin
                            state    <= S_RTS_WAIT;
                            pkt_left <= 2'd0;
                            low_cnt  <= '0;
                        end
                    end
                end
                S_RTS_WAIT: begin
                    cnt     <= '0;
                    bit_idx <= 4'd0;
                    if (c_s2) begin
                        if (!d_s2) begin
                            clk_lo <= 1'b1;
                            state  <= S_RX_BIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RX_BIT: begin
                    if (clk_lo) begin
                        if (cnt == HB_END) begin
                            cnt    <= '0;
                            clk_lo <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (cnt >= SYNC_LAT && !c_s2) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        low_cnt <= '0;
                    end else if (cnt == HB_END) begin
                        cnt    <= '0;
                        clk_lo <= 1'b1;
                        rx_sr  <= {d_s2, rx_sr[9:1]};
                        if (bit_idx == 4'd9) begin
                            bit_idx <= 4'd0;
                            state   <= S_RX_ACK;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RX_ACK: begin
                    if (clk_lo) begin
                        if (cnt == HB_END) begin
                            cnt    <= '0;
                            clk_lo <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (cnt == HB_END) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        q_rd  <= 2'd0;
                        q_cnt <= 2'd1;
                        if (!rx_ok) begin
                            q[0] <= 8'hFE;
                        end else begin
                            q[0]     <= 8'hFA;
                            cmd_byte <= rx_sr[7:0];
                            cmd_tick <= 1'b1;
                            case (rx_sr[7:0])
                                8'hFF: begin
                                    q[1]         <= 8'hAA;
                                    q[2]         <= 8'h00;
                                    q_cnt        <= 2'd3;
                                    reporting_en <= 1'b0;
                                end
                                8'hF4:   reporting_en <= 1'b1;
                                8'hF5:   reporting_en <= 1'b0;
                                default: ;
                            endcase
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_device.sv
// Bench for ps2_mouse_device: host bus model, command/packet stimulus,
// byte scoreboard fed by a frame monitor.
module tb_ps2_mouse_device;

    localparam int HB = 8;
    localparam int RM = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       host_c = 1'b1;
    logic       host_d = 1'b1;
    logic       host_tx = 1'b0;
    logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
    logic       mv_valid = 1'b0;
    logic       mv_ready;
    logic [2:0] mv_btn = 3'd0;
    logic [8:0] mv_dx = 9'd0;
    logic [8:0] mv_dy = 9'd0;
    logic [7:0] cmd_byte;
    logic       cmd_tick, reporting_en, busy;

    int         n_vec = 0;
    int         n_err = 0;
    int         ticks = 0;
    int         mticks = 0;
    logic [7:0] mcmd = 8'h00;
    logic       mrep = 1'b0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    // open-collector wired-AND of host and device drivers
    assign ps2c_in = host_c & ~ps2c_oe;
    assign ps2d_in = host_d & ~ps2d_oe;

    ps2_mouse_device #(.HALF_BIT(HB), .RTS_MIN(RM)) dut (
        .clk(clk), .reset(reset),
        .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .mv_valid(mv_valid), .mv_ready(mv_ready),
        .mv_btn(mv_btn), .mv_dx(mv_dx), .mv_dy(mv_dy),
        .cmd_byte(cmd_byte), .cmd_tick(cmd_tick),
        .reporting_en(reporting_en), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, want);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out, got none required event", nm);
    endtask

    // frame monitor: host samples data on each falling bus clock
    initial begin : mon
        logic [10:0] fr;
        logic [7:0]  e;
        int          nb;
        logic        cp;
        fr = '0;
        nb = 0;
        cp = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || host_tx) begin
                nb = 0;
            end else if (ps2c_oe && !cp) begin
                fr[nb] = ps2d_in;
                nb++;
                if (nb == 11) begin
                    nb = 0;
                    chk("framing", {fr[10], fr[0], ^fr[9:1]}, 3'b101);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %h required none",
                                 fr[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", fr[8:1], e);
                    end
                end
            end
            cp = ps2c_oe;
        end
    end

    initial begin : tick_count
        forever begin
            @(negedge clk);
            if (cmd_tick) ticks++;
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got no end required finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_oe(input logic lv);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ps2c_oe === lv) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("bus_clock");
    endtask

    task automatic wait_empty();
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            timeout("resp_drain");
            exp_q.delete();
        end
    endtask

    task automatic host_send(input logic [7:0] c, input bit bad);
        logic [9:0] bits;
        bits = {1'b1, (~^c) ^ bad, c};
        host_tx = 1'b1;
        @(negedge clk);
        host_c = 1'b0;
        repeat (RM + 2 * HB + 10) @(negedge clk);
        host_d = 1'b0;
        repeat (3) @(negedge clk);
        host_c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_oe(1'b1);
            host_d = bits[i];
            wait_oe(1'b0);
        end
        wait_oe(1'b1);
        repeat (2) @(negedge clk);
        chk("ack_bit", ps2d_in, 1'b0);
        wait_oe(1'b0);
        host_tx = 1'b0;
    endtask

    // reference: expected response bytes and state for one command
    task automatic model_cmd(input logic [7:0] c, input bit bad);
        if (bad) begin
            exp_q.push_back(8'hFE);
        end else begin
            mcmd = c;
            mticks++;
            exp_q.push_back(8'hFA);
            if (c == 8'hFF) begin
                exp_q.push_back(8'hAA);
                exp_q.push_back(8'h00);
                mrep = 1'b0;
            end else if (c == 8'hF4) begin
                mrep = 1'b1;
            end else if (c == 8'hF5) begin
                mrep = 1'b0;
            end
        end
    endtask

    task automatic issue_cmd(input logic [7:0] c, input bit bad);
        model_cmd(c, bad);
        host_send(c, bad);
        wait_empty();
        chk("cmd_byte", cmd_byte, mcmd);
        chk("cmd_ticks", ticks, mticks);
        chk("reporting_en", reporting_en, mrep);
    endtask

    task automatic send_pkt(input int btn, input int dxi, input int dyi,
                            input int nexp);
        int   b1;
        bit   acc;
        logic st;
        b1 = 8 + btn + (dxi < 0 ? 16 : 0) + (dyi < 0 ? 32 : 0);
        exp_q.push_back(8'(b1));
        if (nexp > 1) exp_q.push_back(8'(dxi & 255));
        if (nexp > 2) exp_q.push_back(8'(dyi & 255));
        mv_btn   = 3'(btn);
        mv_dx    = 9'(dxi);
        mv_dy    = 9'(dyi);
        mv_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (mv_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) begin
            timeout("mv_accept");
            mv_valid = 1'b0;
            exp_q.delete();
        end else begin
            @(negedge clk);
            mv_valid = 1'b0;
            st = ps2d_oe;
            if (!st) begin
                @(negedge clk);
                st = ps2d_oe;
            end
            chk("start_latency", st, 1'b1);
        end
    endtask

    initial begin : main
        logic [7:0] c;
        bit         bad;
        repeat (3) @(negedge clk);
        chk("rst_ps2c_oe", ps2c_oe, 1'b0);
        chk("rst_ps2d_oe", ps2d_oe, 1'b0);
        chk("rst_mv_ready", mv_ready, 1'b0);
        chk("rst_cmd_byte", cmd_byte, 8'h00);
        chk("rst_cmd_tick", cmd_tick, 1'b0);
        chk("rst_reporting", reporting_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h00);
        reset = 1'b0;
        wait_empty();

        issue_cmd(8'hF4, 1'b0);
        send_pkt(1, -2, 5, 3);
        wait_empty();
        for (int k = 0; k < 6; k++) begin
            send_pkt(int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 511)) - 256,
                     int'($urandom_range(0, 511)) - 256, 3);
            wait_empty();
        end

        for (int k = 0; k < 8; k++) begin
            c = 8'($urandom);
            if (k % 3 == 0) c = 8'hEA;
            bad = ($urandom_range(0, 3) == 0);
            issue_cmd(c, bad);
        end

        issue_cmd(8'hFF, 1'b0);
        issue_cmd(8'hEA, 1'b1);
        issue_cmd(8'hF4, 1'b0);

        // host interrupts the second packet byte with a command
        send_pkt(int'($urandom_range(0, 7)), 17, -40, 1);
        wait_empty();
        wait_oe(1'b1);
        wait_oe(1'b0);
        wait_oe(1'b1);
        wait_oe(1'b0);
        wait_oe(1'b1);
        issue_cmd(8'hF5, 1'b0);
        repeat (600) @(negedge clk);
        chk("abort_no_byte3", exp_q.size(), 0);

        // reset while a response frame is on the wire
        model_cmd(8'hEA, 1'b0);
        host_send(8'hEA, 1'b0);
        wait_oe(1'b1);
        chk("tx_busy", busy, 1'b1);
        chk("tx_data_low", ps2d_oe, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid_c", ps2c_oe, 1'b0);
        chk("rst_mid_d", ps2d_oe, 1'b0);
        exp_q.delete();
        mcmd = 8'h00;
        mrep = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h00);
        reset = 1'b0;
        wait_empty();
        chk("post_rst_cmd", cmd_byte, mcmd);
        chk("post_rst_rep", reporting_en, mrep);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
